// File: rtl/c1541_gcr_track.sv
// Head model over one GCR track buffer: bit-cell timing, sync/byte decode on read, buffer write-back on write.
// Outputs change on the ce tick ending a bit cell; buf_we follows a byte boundary by one clk, buf_addr by two; no backpressure.
module c1541_gcr_track #(
  parameter int ADDR_W     = 13,
  parameter int BYTE_PULSE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              mtr,
  input  logic              mode,
  input  logic [1:0]        freq,
  input  logic [ADDR_W-1:0] track_len,
  input  logic [7:0]        dout,
  output logic [7:0]        din,
  output logic              sync_n,
  output logic              byte_n,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [7:0]        buf_rdata,
  output logic [7:0]        buf_wdata,
  output logic              buf_we
);
  localparam int PW = $clog2(BYTE_PULSE + 1);

  logic [5:0]        cell_cnt;
  logic [5:0]        cell_last;
  logic [1:0]        freq_r;
  logic [2:0]        track_bit;
  logic [7:0]        rd_sr;
  logic [7:0]        pre;
  logic [9:0]        hist;
  logic [9:0]        hist_nx;
  logic [7:0]        dec_sr;
  logic [7:0]        dec_nx;
  logic [2:0]        dec_cnt;
  logic [PW-1:0]     pulse_cnt;
  logic              mode_r;
  logic [7:0]        wr_lat;
  logic              addr_inc;
  logic [ADDR_W-1:0] addr_nx;
  logic              bit_end;
  logic              boundary;

  // bit period = 4*(16-freq) ticks, so the last tick index is 63 - 4*freq
  assign cell_last = 6'd63 - {2'b00, freq_r, 2'b00};
  assign bit_end   = ce && mtr && (cell_cnt == cell_last);
  assign boundary  = bit_end && (track_bit == 3'd7);
  assign hist_nx   = {hist[8:0], rd_sr[7]};
  assign dec_nx    = {dec_sr[6:0], rd_sr[7]};

  always_comb begin
    addr_nx = buf_addr + 1'b1;
    if (track_len <= ADDR_W'(1) || buf_addr >= track_len - 1'b1)
      addr_nx = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cell_cnt  <= '0;
      freq_r    <= '0;
      track_bit <= '0;
      rd_sr     <= '0;
      pre       <= '0;
      hist      <= '0;
      dec_sr    <= '0;
      dec_cnt   <= '0;
      pulse_cnt <= '0;
      mode_r    <= 1'b1;
      wr_lat    <= '0;
      addr_inc  <= 1'b0;
      din       <= '0;
      sync_n    <= 1'b1;
      byte_n    <= 1'b1;
      buf_addr  <= '0;
      buf_wdata <= '0;
      buf_we    <= 1'b0;
    end else begin
      buf_we <= 1'b0;
      if (addr_inc) begin
        buf_addr <= addr_nx;
        addr_inc <= 1'b0;
      end
      if (!mtr) begin
        sync_n <= 1'b1;
        byte_n <= 1'b1;
      end else if (ce) begin
        if (cell_cnt == 6'd0)
          freq_r <= freq;
        cell_cnt <= bit_end ? 6'd0 : cell_cnt + 6'd1;
        if (track_bit == 3'd4)
          pre <= buf_rdata;
        if (!byte_n) begin
          if (pulse_cnt == '0)
            byte_n <= 1'b1;
          else
            pulse_cnt <= pulse_cnt - 1'b1;
        end
        if (bit_end) begin
          track_bit <= track_bit + 3'd1;
          rd_sr     <= boundary ? pre : {rd_sr[6:0], 1'b0};
          if (mode_r) begin
            hist   <= hist_nx;
            dec_sr <= dec_nx;
            sync_n <= ~&hist_nx;
            if (&hist_nx) begin
              dec_cnt <= '0;
              byte_n  <= 1'b1;
            end else begin
              dec_cnt <= dec_cnt + 3'd1;
              if (dec_cnt == 3'd7) begin
                din       <= dec_nx;
                byte_n    <= 1'b0;
                pulse_cnt <= PW'(BYTE_PULSE - 1);
              end
            end
          end else begin
            dec_cnt <= track_bit + 3'd1;
            sync_n  <= 1'b1;
          end
          if (boundary) begin
            addr_inc <= 1'b1;
            mode_r   <= mode;
            if (mode != mode_r) begin
              hist   <= '0;
              sync_n <= 1'b1;
            end
            // the latch only holds real drive data once a full write byte has passed
            if (!mode) begin
              if (!mode_r) begin
                buf_we    <= 1'b1;
                buf_wdata <= wr_lat;
              end
              wr_lat    <= dout;
              byte_n    <= 1'b0;
              pulse_cnt <= PW'(BYTE_PULSE - 1);
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_c1541_gcr_track.sv
// Bench for c1541_gcr_track: directed track images, expected events queued by the stimulus and
// popped by an independent monitor sampling 2 time units after each rising clock edge.
module tb_c1541_gcr_track;
  localparam int ADDR_W = 13;
  localparam int BP     = 16;

  typedef struct {
    int a;
    int b;
  } ev_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ce = 1'b0;
  logic              mtr = 1'b1;
  logic              mode = 1'b1;
  logic [1:0]        freq = 2'd3;
  logic [ADDR_W-1:0] track_len = 13'd100;
  logic [7:0]        dout = 8'h00;
  logic [7:0]        din;
  logic              sync_n;
  logic              byte_n;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_rdata = 8'h00;
  logic [7:0]        buf_wdata;
  logic              buf_we;

  logic [7:0] mem [0:8191];
  int tk = 0;
  int n_chk = 0;
  int n_pass = 0;
  bit en_addr = 0, en_byte = 0, en_sync = 0, en_we = 0, en_width = 0;
  ev_t q_addr[$];
  ev_t q_byte[$];
  ev_t q_sync[$];
  ev_t q_we[$];

  c1541_gcr_track #(.ADDR_W(ADDR_W), .BYTE_PULSE(BP)) dut (
    .clk(clk), .reset(reset), .ce(ce), .mtr(mtr), .mode(mode), .freq(freq),
    .track_len(track_len), .dout(dout), .din(din), .sync_n(sync_n), .byte_n(byte_n),
    .buf_addr(buf_addr), .buf_rdata(buf_rdata), .buf_wdata(buf_wdata), .buf_we(buf_we)
  );

  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    ce = ~ce;
  end

  always @(posedge clk) begin
    buf_rdata <= mem[buf_addr];
    if (buf_we) mem[buf_addr] <= buf_wdata;
    if (reset) tk <= 0;
    else if (ce && mtr) tk <= tk + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name, input int act);
    n_chk++;
    $display("FAIL %s: got %0h, expected no event / condition", name, act);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 8192; i++) mem[i] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_addr(input int a, input int budget);
    int n = 0;
    while (int'(buf_addr) != a && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (int'(buf_addr) != a) fail("wait_addr_timeout", a);
  endtask

  task automatic wait_tk(input int t, input int budget);
    int n = 0;
    while (tk < t && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (tk < t) fail("wait_tick_timeout", t);
  endtask

  task automatic wait_qaddr(input int budget);
    int n = 0;
    while (q_addr.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q_addr.size() != 0) fail("wait_addr_queue_timeout", q_addr.size());
  endtask

  // monitor
  initial begin
    logic [ADDR_W-1:0] p_addr;
    logic p_byte, p_sync;
    int last_addr_tk, fall_tk;
    ev_t e;
    p_addr = '0; p_byte = 1'b1; p_sync = 1'b1; last_addr_tk = 0; fall_tk = 0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        last_addr_tk = 0;
        fall_tk = 0;
      end else begin
        if (buf_addr != p_addr) begin
          if (en_addr) begin
            if (q_addr.size() == 0) fail("addr_unexpected", int'(buf_addr));
            else begin
              e = q_addr.pop_front();
              check("addr_value", buf_addr, e.a);
              if (e.b >= 0) check("addr_interval", tk - last_addr_tk, e.b);
            end
          end
          last_addr_tk = tk;
        end
        if (p_byte && !byte_n) begin
          if (en_byte) begin
            if (q_byte.size() == 0) fail("byte_unexpected", int'(din));
            else begin
              e = q_byte.pop_front();
              check("byte_din", din, e.a);
              if (e.b >= 0) check("byte_tick", tk, e.b);
            end
          end
          fall_tk = tk;
        end
        if (!p_byte && byte_n && en_width) check("byte_width", tk - fall_tk, BP);
        if (sync_n != p_sync && en_sync) begin
          if (q_sync.size() == 0) fail("sync_unexpected", int'(sync_n));
          else begin
            e = q_sync.pop_front();
            check("sync_value", sync_n, e.a);
            check("sync_tick", tk, e.b);
          end
        end
        if (buf_we && en_we) begin
          if (q_we.size() == 0) fail("we_unexpected", int'(buf_addr));
          else begin
            e = q_we.pop_front();
            check("we_addr", buf_addr, e.a);
            check("we_data", buf_wdata, e.b);
          end
        end
      end
      p_addr = buf_addr;
      p_byte = byte_n;
      p_sync = sync_n;
    end
  end

  initial begin
    // reset state
    fill(8'h55);
    repeat (3) @(negedge clk);
    check("rst_din", din, 8'h00);
    check("rst_sync_n", sync_n, 1'b1);
    check("rst_byte_n", byte_n, 1'b1);
    check("rst_buf_addr", buf_addr, 0);
    check("rst_buf_we", buf_we, 1'b0);
    check("rst_buf_wdata", buf_wdata, 8'h00);

    // byte timing at freq 3 then freq 0
    en_addr = 1;
    q_addr.push_back('{1, 416});
    q_addr.push_back('{2, 416});
    q_addr.push_back('{3, 416});
    reset = 1'b0;
    wait_addr(3, 4000);
    freq = 2'd0;
    q_addr.push_back('{4, 512});
    q_addr.push_back('{5, 512});
    wait_addr(5, 3000);
    check("q_addr_empty_freq", q_addr.size(), 0);
    en_addr = 0;

    // sync detection and byte decode, 64 ticks per bit
    fill(8'h00);
    mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'h52; mem[3] = 8'h54;
    do_reset();
    en_byte = 1; en_sync = 1; en_width = 1;
    q_byte.push_back('{8'h00, 512});
    q_byte.push_back('{8'hFF, 1024});
    q_byte.push_back('{8'h52, 2048});
    q_byte.push_back('{8'h54, 2560});
    q_byte.push_back('{8'h00, 3072});
    q_sync.push_back('{0, 1152});
    q_sync.push_back('{1, 1600});
    wait_tk(3100, 8000);
    check("q_byte_empty_sync", q_byte.size(), 0);
    check("q_sync_empty", q_sync.size(), 0);
    en_byte = 0; en_sync = 0; en_width = 0;

    // write path
    fill(8'h00);
    freq = 2'd3;
    do_reset();
    en_we = 1;
    wait_addr(2, 3000);
    mode = 1'b0;
    dout = 8'hAA;
    en_byte = 1;
    q_byte.push_back('{8'h00, 1248});
    q_byte.push_back('{8'h00, 1664});
    q_byte.push_back('{8'h00, 2080});
    q_we.push_back('{3, 8'hAA});
    q_we.push_back('{4, 8'h5B});
    wait_addr(3, 2000);
    dout = 8'h5B;
    wait_addr(4, 2000);
    dout = 8'h11;
    wait_addr(5, 2000);
    mode = 1'b1;
    en_byte = 0;
    check("q_we_empty", q_we.size(), 0);
    check("q_byte_empty_write", q_byte.size(), 0);
    check("mem3", mem[3], 8'hAA);
    check("mem4", mem[4], 8'h5B);
    wait_addr(6, 2000);
    en_we = 0;

    // wrap at track_len, then track_len 0 pins the address
    fill(8'h55);
    track_len = 13'd10;
    do_reset();
    en_addr = 1;
    for (int i = 1; i <= 9; i++) q_addr.push_back('{i, 416});
    q_addr.push_back('{0, 416});
    q_addr.push_back('{1, 416});
    wait_qaddr(12000);
    track_len = 13'd0;
    q_addr.push_back('{0, 416});
    wait_tk(tk + 4 * 416, 5000);
    check("q_addr_empty_len", q_addr.size(), 0);
    check("len0_addr", buf_addr, 0);
    en_addr = 0;

    // motor stop mid-pulse, resume from saved position
    track_len = 13'd100;
    do_reset();
    en_addr = 1; en_we = 1;
    q_addr.push_back('{1, 416});
    q_addr.push_back('{2, 416});
    wait_addr(1, 1500);
    wait_tk(421, 200);
    check("mtr_pre_byte_n", byte_n, 1'b0);
    mtr = 1'b0;
    @(negedge clk);
    check("mtr_off_byte_n", byte_n, 1'b1);
    check("mtr_off_sync_n", sync_n, 1'b1);
    repeat (300) @(negedge clk);
    check("mtr_off_addr", buf_addr, 1);
    mtr = 1'b1;
    wait_addr(2, 1500);
    check("q_addr_empty_mtr", q_addr.size(), 0);
    en_addr = 0; en_we = 0;

    // reset during a read pulse
    do_reset();
    wait_tk(835, 2500);
    check("rp_pre_din", din, 8'h55);
    check("rp_pre_byte_n", byte_n, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("rp_din", din, 8'h00);
    check("rp_byte_n", byte_n, 1'b1);
    check("rp_sync_n", sync_n, 1'b1);
    check("rp_buf_addr", buf_addr, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end
endmodule
